// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: checks the BTB prediction against the actual outcome,
// drives fetch redirect, timed flush and BTB training. `define BRANCH_STATS_EN adds counters.
module branch_resolver #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_br,
    input  logic        ex_taken,
    input  logic [29:0] ex_pc,
    input  logic [29:0] ex_target,
    input  logic        ex_phit,
    input  logic [29:0] ex_paddr,
    output logic        redirect_en,
    output logic [29:0] redirect_pc,
    output logic        flush,
    output logic        upEN,
    output logic [29:0] tag,
    output logic [29:0] br_a
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    logic        vld_p0;
    logic        mispredict_p0;
    logic        train_p0;
    logic [29:0] fix_pc_p0;

    // Sequential fall-through address; the 30-bit word space wraps naturally.
    function automatic logic [29:0] next_word(input logic [29:0] pc);
        return pc + 30'd1;
    endfunction

    // Stage p0: decode the resolution from the execute-stage inputs
    always_comb begin
        vld_p0        = (state == IDLE) && ex_valid && !ex_stall;
        train_p0      = ex_is_br && ex_taken && (!ex_phit || (ex_paddr != ex_target));
        mispredict_p0 = train_p0 || (ex_phit && !(ex_is_br && ex_taken));
        fix_pc_p0     = (ex_is_br && ex_taken) ? ex_target : next_word(ex_pc);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (vld_p0 && mispredict_p0) begin
                    state_next = FLUSH;
                    cnt_next   = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) state_next = IDLE;
                else             cnt_next   = cnt - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Flush squashes younger instructions for as long as the FSM is draining
    assign flush = (state == FLUSH);

    // Stage p1: registered redirect and BTB write
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            redirect_en <= 1'b0;
            redirect_pc <= 30'd0;
            upEN        <= 1'b0;
            tag         <= 30'd0;
            br_a        <= 30'd0;
        end else begin
            redirect_en <= vld_p0 && mispredict_p0;
            upEN        <= vld_p0 && train_p0;
            if (vld_p0 && mispredict_p0) redirect_pc <= fix_pc_p0;
            if (vld_p0 && train_p0) begin
                tag  <= ex_pc;
                br_a <= ex_target;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            br_count <= 32'd0;
            mp_count <= 32'd0;
        end else begin
            if (vld_p0 && ex_is_br)      br_count <= br_count + 32'd1;
            if (vld_p0 && mispredict_p0) mp_count <= mp_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed vector table, randomized run against a
// behavioural model, and a FLUSH_CYCLES=3 instance for mid-flush reset and flush length.
module tb_branch_resolver;

    localparam int FC = 2;

    logic        CLK, nRST, nrst3;
    logic        ex_valid, ex_stall, ex_is_br, ex_taken, ex_phit;
    logic [29:0] ex_pc, ex_target, ex_paddr;
    logic        redirect_en, flush, upEN;
    logic [29:0] redirect_pc, tag, br_a;
    logic        redirect_en3, flush3, upEN3;
    logic [29:0] redirect_pc3, tag3, br_a3;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, mp_count, br_count3, mp_count3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    branch_resolver #(.FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_br(ex_is_br), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_phit(ex_phit), .ex_paddr(ex_paddr), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .flush(flush), .upEN(upEN), .tag(tag), .br_a(br_a)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count), .mp_count(mp_count)
`endif
    );

    branch_resolver #(.FLUSH_CYCLES(3)) dut3 (
        .CLK(CLK), .nRST(nrst3), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_br(ex_is_br), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_phit(ex_phit), .ex_paddr(ex_paddr), .redirect_en(redirect_en3),
        .redirect_pc(redirect_pc3), .flush(flush3), .upEN(upEN3), .tag(tag3), .br_a(br_a3)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count3), .mp_count(mp_count3)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: remaining flush cycles plus last-written output values
    int          m_left;
    logic        m_redir, m_up;
    logic [29:0] m_rpc, m_tag, m_bra;
    logic [31:0] m_brc, m_mpc;

    task automatic model_reset();
        m_left = 0; m_redir = 0; m_up = 0;
        m_rpc = 0; m_tag = 0; m_bra = 0; m_brc = 0; m_mpc = 0;
    endtask

    task automatic model_edge();
        logic busy, res, mp, tr;
        logic [29:0] fix;
        busy = (m_left > 0);
        res  = !busy && ex_valid && !ex_stall;
        if (!ex_is_br) begin
            mp = ex_phit; fix = ex_pc + 30'd1; tr = 1'b0;
        end else if (ex_taken) begin
            mp = !ex_phit || (ex_paddr != ex_target); fix = ex_target; tr = mp;
        end else begin
            mp = ex_phit; fix = ex_pc + 30'd1; tr = 1'b0;
        end
        m_redir = res && mp;
        m_up    = res && tr;
        if (res && mp) m_rpc = fix;
        if (res && tr) begin m_tag = ex_pc; m_bra = ex_target; end
        if (res && ex_is_br) m_brc = m_brc + 1;
        if (res && mp)       m_mpc = m_mpc + 1;
        if (res && mp)  m_left = FC;
        else if (busy)  m_left = m_left - 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic b, input logic t,
                         input logic h, input logic [29:0] pc, input logic [29:0] tg,
                         input logic [29:0] pa);
        ex_valid = v; ex_stall = s; ex_is_br = b; ex_taken = t;
        ex_phit = h; ex_pc = pc; ex_target = tg; ex_paddr = pa;
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".redirect_en"}, 32'(redirect_en), 32'(m_redir));
        chk({nm, ".redirect_pc"}, 32'(redirect_pc), 32'(m_rpc));
        chk({nm, ".flush"},       32'(flush),       32'(m_left > 0));
        chk({nm, ".upEN"},        32'(upEN),        32'(m_up));
        chk({nm, ".tag"},         32'(tag),         32'(m_tag));
        chk({nm, ".br_a"},        32'(br_a),        32'(m_bra));
`ifdef BRANCH_STATS_EN
        chk({nm, ".br_count"},    br_count,         m_brc);
        chk({nm, ".mp_count"},    mp_count,         m_mpc);
`endif
    endtask

    typedef struct {
        logic        v, s, b, t, h;
        logic [29:0] pc, tg, pa;
        logic        redir;
        logic [29:0] rpc;
        logic        fl, up;
        logic [29:0] etag, ebra;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic v, input logic s, input logic b, input logic t,
                                input logic h, input logic [29:0] pc, input logic [29:0] tg,
                                input logic [29:0] pa, input logic redir, input logic [29:0] rpc,
                                input logic fl, input logic up, input logic [29:0] etag,
                                input logic [29:0] ebra);
        vec_t r;
        r.v = v; r.s = s; r.b = b; r.t = t; r.h = h; r.pc = pc; r.tg = tg; r.pa = pa;
        r.redir = redir; r.rpc = rpc; r.fl = fl; r.up = up; r.etag = etag; r.ebra = ebra;
        return r;
    endfunction

    initial begin
        //          v s b t h  pc           target  paddr   redir rpc     fl up tag     br_a
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h0,   0, 0, 30'h0,   30'h0));
        vt.push_back(mk(1,0,1,1,0, 30'h100,     30'h200, 30'h0,  1, 30'h200, 1, 1, 30'h100, 30'h200));
        vt.push_back(mk(1,0,1,1,0, 30'h500,     30'h600, 30'h0,  0, 30'h200, 1, 0, 30'h100, 30'h200));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h200, 0, 0, 30'h100, 30'h200));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(1,0,1,1,1, 30'h100, 30'h200, 30'h200, 0, 30'h200, 0, 0, 30'h100, 30'h200));
        vt.push_back(mk(1,0,1,0,1, 30'h3FFFFFFF, 30'h5, 30'h5,   1, 30'h0,   1, 0, 30'h100, 30'h200));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h0,   1, 0, 30'h100, 30'h200));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h0,   0, 0, 30'h100, 30'h200));
        vt.push_back(mk(1,0,1,1,1, 30'h10,      30'h80,  30'h40, 1, 30'h80,  1, 1, 30'h10,  30'h80));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h80,  1, 0, 30'h10,  30'h80));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h80,  0, 0, 30'h10,  30'h80));
        vt.push_back(mk(1,1,1,1,1, 30'h11,      30'h90,  30'h40, 0, 30'h80,  0, 0, 30'h10,  30'h80));
        vt.push_back(mk(1,1,1,1,1, 30'h11,      30'h90,  30'h40, 0, 30'h80,  0, 0, 30'h10,  30'h80));
        vt.push_back(mk(1,0,1,1,1, 30'h11,      30'h90,  30'h40, 1, 30'h90,  1, 1, 30'h11,  30'h90));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h90,  1, 0, 30'h11,  30'h90));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h90,  0, 0, 30'h11,  30'h90));
        vt.push_back(mk(1,0,0,0,1, 30'h20,      30'h0,   30'h99, 1, 30'h21,  1, 0, 30'h11,  30'h90));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h21,  1, 0, 30'h11,  30'h90));
        vt.push_back(mk(0,0,0,0,0, 30'h0,       30'h0,   30'h0,  0, 30'h21,  0, 0, 30'h11,  30'h90));
        vt.push_back(mk(1,0,1,0,0, 30'h40,      30'h77,  30'h0,  0, 30'h21,  0, 0, 30'h11,  30'h90));
        vt.push_back(mk(1,0,1,1,1, 30'h50,      30'h70,  30'h70, 0, 30'h21,  0, 0, 30'h11,  30'h90));
        vt.push_back(mk(1,0,0,0,0, 30'h60,      30'h0,   30'h0,  0, 30'h21,  0, 0, 30'h11,  30'h90));

        // Reset state
        nRST = 1'b0; nrst3 = 1'b0;
        drive(0, 0, 0, 0, 0, 30'h0, 30'h0, 30'h0);
        model_reset();
        #12;
        chk("rst.redirect_en", 32'(redirect_en), 32'd0);
        chk("rst.redirect_pc", 32'(redirect_pc), 32'd0);
        chk("rst.flush",       32'(flush),       32'd0);
        chk("rst.upEN",        32'(upEN),        32'd0);
        chk("rst.tag",         32'(tag),         32'd0);
        chk("rst.br_a",        32'(br_a),        32'd0);
        nRST = 1'b1; nrst3 = 1'b1;

        // Directed vector table
        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].s, vt[i].b, vt[i].t, vt[i].h, vt[i].pc, vt[i].tg, vt[i].pa);
            step();
            chk($sformatf("vec%0d.redirect_en", i), 32'(redirect_en), 32'(vt[i].redir));
            chk($sformatf("vec%0d.redirect_pc", i), 32'(redirect_pc), 32'(vt[i].rpc));
            chk($sformatf("vec%0d.flush", i),       32'(flush),       32'(vt[i].fl));
            chk($sformatf("vec%0d.upEN", i),        32'(upEN),        32'(vt[i].up));
            chk($sformatf("vec%0d.tag", i),         32'(tag),         32'(vt[i].etag));
            chk($sformatf("vec%0d.br_a", i),        32'(br_a),        32'(vt[i].ebra));
`ifdef BRANCH_STATS_EN
            chk($sformatf("vec%0d.br_count", i), br_count, m_brc);
            chk($sformatf("vec%0d.mp_count", i), mp_count, m_mpc);
`endif
        end

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic [29:0] pc, tg;
            pc = ($urandom_range(9) == 0) ? 30'h3FFFFFFF : 30'($urandom);
            tg = 30'($urandom);
            drive(1'($urandom_range(99) < 75), 1'($urandom_range(99) < 20),
                  1'($urandom_range(99) < 70), 1'($urandom_range(1)),
                  1'($urandom_range(1)), pc, tg,
                  ($urandom_range(1) == 1) ? tg : 30'($urandom));
            step();
            check_model($sformatf("rnd%0d", i));
        end

        // FLUSH_CYCLES=3 instance: reset asserted during the 2nd flush cycle
        nRST = 1'b0; nrst3 = 1'b0;
        drive(0, 0, 0, 0, 0, 30'h0, 30'h0, 30'h0);
        model_reset();
        #2;
        nRST = 1'b1; nrst3 = 1'b1;
        drive(1, 0, 1, 1, 0, 30'h100, 30'h200, 30'h0);
        step();
        chk("fc3.mp.redirect_en", 32'(redirect_en3), 32'd1);
        chk("fc3.mp.flush",       32'(flush3),       32'd1);
        check_model("fc3.mp.main");
        drive(0, 0, 0, 0, 0, 30'h0, 30'h0, 30'h0);
        step();
        chk("fc3.flush2", 32'(flush3), 32'd1);
        nrst3 = 1'b0;
        #1;
        chk("fc3.rst.flush",       32'(flush3),       32'd0);
        chk("fc3.rst.redirect_en", 32'(redirect_en3), 32'd0);
        chk("fc3.rst.redirect_pc", 32'(redirect_pc3), 32'd0);
        chk("fc3.rst.upEN",        32'(upEN3),        32'd0);
        chk("fc3.rst.tag",         32'(tag3),         32'd0);
        chk("fc3.rst.br_a",        32'(br_a3),        32'd0);
        #2;
        nrst3 = 1'b1;
        drive(1, 0, 1, 1, 1, 30'h100, 30'h200, 30'h200);
        step();
        chk("fc3.ok.redirect_en", 32'(redirect_en3), 32'd0);
        chk("fc3.ok.flush",       32'(flush3),       32'd0);
        chk("fc3.ok.upEN",        32'(upEN3),        32'd0);

        // FLUSH_CYCLES=3 flush length
        drive(1, 0, 1, 0, 1, 30'h300, 30'h0, 30'h0);
        step();
        chk("fc3.len.redirect_pc", 32'(redirect_pc3), 32'h301);
        drive(0, 0, 0, 0, 0, 30'h0, 30'h0, 30'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fc3.len%0d.flush", k), 32'(flush3), (k < 3) ? 32'd1 : 32'd0);
            step();
        end
`ifdef BRANCH_STATS_EN
        chk("fc3.br_count", br_count3, 32'd2);
        chk("fc3.mp_count", mp_count3, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit sitting directly downstream of the branch target buffer. It compares the fetch-time prediction (hit flag and predicted target) that travels with each instruction against the actual outcome computed in execute. On a mismatch it issues a fetch redirect and drives a timed pipeline flush. It also generates the single-cycle BTB write (upEN/tag/br_a) that trains the predictor.

## Interface
- FLUSH_CYCLES, 2, number of cycles flush stays high per mispredict; legal range 1..15
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ex_valid  in  1  instruction in execute is valid
- ex_stall  in  1  execute stage stalled; inputs not sampled
- ex_is_br  in  1  instruction is a branch or jump
- ex_taken  in  1  actual outcome is taken (jumps always 1)
- ex_pc  in  30  word address of the instruction
- ex_target  in  30  actual taken target, word address
- ex_phit  in  1  fetch predicted taken via BTB hit
- ex_paddr  in  30  predicted target, word address
- redirect_en  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  30  corrected fetch word address
- flush  out  1  squash younger instructions in IF/ID
- upEN  out  1  one-cycle BTB write enable
- tag  out  30  BTB write index/tag (the branch's word PC)
- br_a  out  30  BTB write target

## Operation
- A resolution happens in a cycle when state is IDLE, ex_valid=1 and ex_stall=0; nothing is sampled otherwise.
- Mispredict cases, with the resulting redirect_pc:
  - ex_is_br & ex_taken & !ex_phit → ex_target
  - ex_is_br & ex_taken & ex_phit & ex_paddr≠ex_target → ex_target
  - ex_is_br & !ex_taken & ex_phit → ex_pc+1
  - !ex_is_br & ex_phit (alias hit) → ex_pc+1
- Correct prediction: phit with matching target on a taken branch, or no phit on a not-taken branch or non-branch.
- ex_pc+1 wraps modulo 2^30.
- BTB training: a resolved ex_is_br & ex_taken with (!ex_phit or ex_paddr≠ex_target) raises upEN with tag=ex_pc and br_a=ex_target. No other event writes the BTB; not-taken branches never write.
- FSM states:
  - IDLE → FLUSH on a mispredict; the counter loads FLUSH_CYCLES-1.
  - FLUSH: flush=1; counter decrements every cycle, regardless of ex_stall. At 0 the next state is IDLE.
  - In FLUSH, ex_valid is ignored: wrong-path instructions are neither resolved nor trained.

## Timing
- Reset values: redirect_en=0, redirect_pc=0, flush=0, upEN=0, tag=0, br_a=0; state IDLE; counter 0.
- All outputs are registered. Inputs resolved at edge N appear at edge N+1.
- redirect_en is high for exactly cycle N+1.
- flush is high from N+1 through N+FLUSH_CYCLES inclusive.
- The first new resolution is possible at cycle N+FLUSH_CYCLES+1.
- upEN is high for exactly cycle N+1. tag and br_a hold their last written values when upEN=0.
- A mispredict that also trains raises redirect_en and upEN in the same cycle.
- Back-to-back correct branches resolve every cycle, with no bubble.
- nRST asserted mid-FLUSH returns immediately to IDLE with all outputs at reset values.

## Configuration
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_count (out, 32) and mp_count (out, 32), both reset to 0.
  - br_count increments on each resolution with ex_is_br=1.
  - mp_count increments on each mispredict, including alias hits.
  - Both are registered and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then idle with ex_valid=0 → every output stays 0 and no FSM transition occurs.
- Taken branch: ex_pc=0x100, ex_target=0x200, ex_phit=0 → next cycle redirect_en=1, redirect_pc=0x200, upEN=1, tag=0x100, br_a=0x200. flush is high for 2 cycles. An ex_valid branch presented during the flush is ignored.
- Same branch with ex_phit=1, ex_paddr=0x200, issued on 3 consecutive cycles → no redirect, no flush, no upEN. With BRANCH_STATS_EN: br_count=3, mp_count=0.
- Not-taken branch: ex_pc=0x3FFFFFFF, ex_phit=1 → redirect_pc=0 (wrap), upEN=0, flush for FLUSH_CYCLES cycles.
- Target mismatch: ex_phit=1, ex_paddr=0x40, ex_target=0x80 → redirect_pc=0x80, upEN=1, br_a=0x80. The same mispredict with ex_stall=1 → no response until stall drops.
- FLUSH_CYCLES=3: assert nRST during the 2nd flush cycle → flush=0 immediately; a correct-prediction branch presented on the first cycle after reset release resolves with no redirect.
